fetch_controller: RTL and testbench

//  Sequences the instruction ROM: owns the fetch PC, issues word addresses to the
//  1-cycle-latency synchronous ROM, buffers returned words and hands them to decode

---
 rtl/miniRISC_pkg.sv | 21 ++
 rtl/fetch_buffer.sv | 57 +++++
 rtl/fetch_controller.sv | 110 +++++++++++
 tb/tb_fetch_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miniRISC_pkg.sv
// Shared miniRISC definitions: widths, fetch FSM states and common encodings.
package miniRISC_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_DRAIN  = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;

    // Sequential word-address successor; wraps at 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO with synchronous flush; push and pop may coincide when full.
module fetch_buffer
    import miniRISC_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [PC_W-1:0]   head_pc,
    output logic [DATA_W-1:0] head_data
);

    logic [PC_W-1:0]   pc_q   [2];
    logic [DATA_W-1:0] data_q [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              do_push;
    logic              do_pop;

    // A full buffer can still take a word when the head leaves in the same cycle.
    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && ((count != 2'd2) || do_pop);
    assign wr_ptr    = rd_ptr ^ count[0];
    assign head_pc   = pc_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    // Storage, read pointer and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr]   <= push_pc;
                data_q[wr_ptr] <= push_data;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch: owns the fetch PC, drives the 1-cycle ROM and feeds decode.
module fetch_controller
    import miniRISC_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 12,
    parameter int unsigned     DATA_W   = INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt_req,
    input  logic              resume,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [PC_W-1:0]   instr_pc,
    output logic              halted
);

    fetch_state_t      state;
    logic              started;
    logic              inflight;
    logic [PC_W-1:0]   inflight_pc;
    logic [PC_W-1:0]   fetch_pc;
    logic [1:0]        count;
    logic [PC_W-1:0]   head_pc;
    logic [DATA_W-1:0] head_data;
    logic              pop;
    logic              push;
    logic [2:0]        after_pop;

    // The word returning from the ROM is visible to decode in the cycle it arrives,
    // so an empty buffer does not add a cycle of latency.
    assign instr_valid = (count != 2'd0) || inflight;
    assign instr       = (count != 2'd0) ? head_data : (inflight ? rom_data : '0);
    assign instr_pc    = (count != 2'd0) ? head_pc : (inflight ? inflight_pc : '0);
    assign pop         = instr_valid && instr_ready;

    // Only words not consumed directly off the ROM port are captured.
    assign push        = inflight && !(pop && (count == 2'd0));

    // Issue only if the word we request next cycle is guaranteed a buffer slot.
    assign after_pop   = 3'(count) + 3'(inflight) - 3'(pop);
    assign rom_en      = started && (state == FS_RUN) && !redirect_valid && (after_pop < 3'd2);
    assign rom_addr    = fetch_pc[ADDR_W-1:0];

    assign halted      = (state == FS_HALTED) && (count == 2'd0) && !inflight;

    fetch_buffer #(
        .DATA_W(DATA_W)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (push),
        .push_pc  (inflight_pc),
        .push_data(rom_data),
        .pop      (pop),
        .count    (count),
        .head_pc  (head_pc),
        .head_data(head_data)
    );

    // Fetch PC, in-flight tag and run/drain/halt state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FS_RUN;
            started     <= 1'b0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fetch_pc    <= RESET_PC;
        end else begin
            started  <= 1'b1;
            // rom_en is low during a redirect, which also squashes the return.
            inflight <= rom_en;
            if (rom_en) begin
                inflight_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (rom_en) begin
                fetch_pc <= pc_inc(fetch_pc);
            end
            case (state)
                FS_RUN: begin
                    if (halt_req) begin
                        state <= FS_DRAIN;
                    end
                end
                FS_DRAIN: begin
                    if (!inflight) begin
                        state <= FS_HALTED;
                    end
                end
                FS_HALTED: begin
                    if (resume && !halt_req) begin
                        state <= FS_RUN;
                    end
                end
                default: state <= FS_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with a 1-cycle ROM model (mem[a] = A000_0000 + a).
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_q[$];

    fetch_controller dut (
        .clk           (clk),
        .rst           (rst),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .resume        (resume),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .halted        (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: data appears the cycle after the read strobe.
    initial rom_data = 32'd0;
    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'hA000_0000 + 32'(rom_addr);
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        logic [11:0] a;
        a = pc[11:0];
        return 32'hA000_0000 + {20'd0, a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i));
    endtask

    // Leaves the caller at the posedge on which the last expected word transferred.
    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Every transfer to decode must match the next expected word.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_stray_pc", instr_pc, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check_eq("sb_pc", instr_pc, e);
                check_eq("sb_instr", instr, exp_instr(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        n_checks       = 0;
        n_pass         = 0;
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt_req       = 1'b0;
        resume         = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_rom_en", rom_en, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc", instr_pc, 32'd0);

        // Startup latency and streaming
        @(posedge clk);
        #1 rst = 1'b0;
        instr_ready = 1'b1;
        expect_seq(32'd0, 10);
        @(negedge clk);
        check_eq("start_rom_en0", rom_en, 1'b0);
        @(negedge clk);
        check_eq("start_rom_en1", rom_en, 1'b1);
        check_eq("start_addr", 32'(rom_addr), 32'd0);
        check_eq("start_valid1", instr_valid, 1'b0);
        @(negedge clk);
        check_eq("start_valid2", instr_valid, 1'b1);
        wait_drain(50);

        // Backpressure: hold for 5 cycles, then continue without gap or duplicate
        #1 instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_valid", instr_valid, 1'b1);
            check_eq("stall_pc", instr_pc, 32'd10);
            check_eq("stall_instr", instr, 32'hA000_000A);
            if (i >= 2) check_eq("stall_rom_en", rom_en, 1'b0);
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        expect_seq(32'd10, 10);
        wait_drain(50);

        // Redirect with a buffered word plus one in flight
        #1 instr_ready = 1'b0;
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        check_eq("redir_rom_en", rom_en, 1'b0);
        check_eq("redir_old_pc", instr_pc, 32'd20);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        instr_ready = 1'b1;
        expect_seq(32'h40, 8);
        @(negedge clk);
        check_eq("redir_gap", instr_valid, 1'b0);
        check_eq("redir_issue_addr", 32'(rom_addr), 32'h40);
        @(negedge clk);
        check_eq("redir_valid", instr_valid, 1'b1);
        wait_drain(50);

        // Halt pulse in the cycle pc 7 issues, then resume
        #1 instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        instr_ready = 1'b1;
        expect_seq(32'd0, 8);
        n = 0;
        while (!(rom_en && rom_addr == 12'd7) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("halt_issue_addr", 32'(rom_addr), 32'd7);
        halt_req = 1'b1;
        @(posedge clk);
        #1 halt_req = 1'b0;
        n = 0;
        while (!halted && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("halted", halted, 1'b1);
        check_eq("halt_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("halt_rom_en", rom_en, 1'b0);
            check_eq("halt_valid", instr_valid, 1'b0);
        end
        @(posedge clk);
        #1 resume = 1'b1;
        expect_seq(32'd8, 4);
        @(posedge clk);
        #1 resume = 1'b0;
        @(negedge clk);
        check_eq("resume_halted", halted, 1'b0);
        check_eq("resume_addr", 32'(rom_addr), 32'd8);
        wait_drain(50);

        // ROM address wraps while the PC keeps counting
        #1 instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0FFF;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        instr_ready = 1'b1;
        expect_seq(32'h0000_0FFF, 3);
        @(negedge clk);
        check_eq("wrap_addr0", 32'(rom_addr), 32'h0FFF);
        @(negedge clk);
        check_eq("wrap_addr1", 32'(rom_addr), 32'h0000);
        wait_drain(50);

        // Asynchronous reset mid-stream
        #1 instr_ready = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_valid", instr_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_valid", instr_valid, 1'b0);
        check_eq("arst_instr", instr, 32'd0);
        check_eq("arst_pc", instr_pc, 32'd0);
        check_eq("arst_rom_en", rom_en, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        instr_ready = 1'b1;
        expect_seq(32'd0, 4);
        wait_drain(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
